// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler sharing one simple_spi byte master among N_REQ multi-byte requesters.
// Define SPI_SCHED_TIMEOUT_EN to enable the WAIT_RX watchdog (o_err), otherwise o_err stays 0.
module spi_txn_scheduler #(
   parameter int unsigned N_REQ          = 2,
   parameter int unsigned DATA_N_BIT     = 8,
   parameter int unsigned N_SLAVES       = 1,
   parameter int unsigned LEN_BITS       = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned SLV_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
   input  logic                          i_clk,
   input  logic                          i_sync_rst_n,
   input  logic [N_REQ-1:0]              i_req,
   input  logic [N_REQ*SLV_W-1:0]        i_req_slave,
   input  logic [N_REQ*LEN_BITS-1:0]     i_req_len,
   input  logic [N_REQ*DATA_N_BIT-1:0]   i_req_data,
   output logic [N_REQ-1:0]              o_grant,
   output logic [N_REQ-1:0]              o_data_ack,
   output logic [DATA_N_BIT-1:0]         o_rd_data,
   output logic [N_REQ-1:0]              o_rd_valid,
   output logic [N_REQ-1:0]              o_done,
   output logic [N_REQ-1:0]              o_err,
   output logic [SLV_W-1:0]              o_spi_slave_num,
   output logic [DATA_N_BIT-1:0]         o_spi_tx_data,
   output logic                          o_spi_tx_data_valid,
   input  logic                          i_spi_tx_ready,
   input  logic [DATA_N_BIT-1:0]         i_spi_rx_data,
   input  logic                          i_spi_rx_data_valid
);

   localparam int unsigned OWN_W = $clog2(N_REQ);

   typedef enum logic [1:0] {StIdle, StSend, StWaitRx, StDone} state_e;

   state_e                state_q;
   logic [OWN_W-1:0]      owner_q;
   logic [OWN_W-1:0]      last_q;
   logic [LEN_BITS-1:0]   cnt_q;
   logic [SLV_W-1:0]      slave_q;
   logic [N_REQ-1:0]      grant_q;
   logic [N_REQ-1:0]      ack_q;
   logic [N_REQ-1:0]      rd_valid_q;
   logic [N_REQ-1:0]      done_q;
   logic [N_REQ-1:0]      err_q;
   logic [DATA_N_BIT-1:0] rd_data_q;
   logic [DATA_N_BIT-1:0] tx_data_q;
   logic                  tx_valid_q;

   logic [OWN_W-1:0]      pick;
   logic                  pick_vld;
   logic [N_REQ-1:0]      pick_oh;
   logic [N_REQ-1:0]      owner_oh;
   logic                  tmo_hit;

   // Scan upward from the requester after the last owner, wrapping.
   always_comb begin
      logic [OWN_W-1:0] idx;
      idx      = '0;
      pick     = last_q;
      pick_vld = 1'b0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = OWN_W'((32'(last_q) + i) % N_REQ);
         if (!pick_vld && i_req[idx]) begin
            pick_vld = 1'b1;
            pick     = idx;
         end
      end
   end

   assign pick_oh  = N_REQ'(1) << pick;
   assign owner_oh = N_REQ'(1) << owner_q;

`ifdef SPI_SCHED_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q;
   assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_sync_rst_n) begin
         state_q    <= StIdle;
         owner_q    <= '0;
         last_q     <= OWN_W'(N_REQ - 1);
         cnt_q      <= '0;
         slave_q    <= '0;
         grant_q    <= '0;
         ack_q      <= '0;
         rd_valid_q <= '0;
         done_q     <= '0;
         err_q      <= '0;
         rd_data_q  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
         tmo_q      <= '0;
`endif
      end else begin
         ack_q      <= '0;
         rd_valid_q <= '0;
         done_q     <= '0;
         err_q      <= '0;
         tx_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pick_vld) begin
                  owner_q <= pick;
                  slave_q <= i_req_slave[32'(pick)*SLV_W +: SLV_W];
                  cnt_q   <= i_req_len[32'(pick)*LEN_BITS +: LEN_BITS];
                  grant_q <= pick_oh;
                  state_q <= StSend;
               end
            end
            StSend: begin
               if (i_spi_tx_ready) begin
                  tx_data_q  <= i_req_data[32'(owner_q)*DATA_N_BIT +: DATA_N_BIT];
                  tx_valid_q <= 1'b1;
                  ack_q      <= owner_oh;
                  state_q    <= StWaitRx;
`ifdef SPI_SCHED_TIMEOUT_EN
                  tmo_q      <= '0;
`endif
               end
            end
            StWaitRx: begin
               if (i_spi_rx_data_valid) begin
                  rd_data_q  <= i_spi_rx_data;
                  rd_valid_q <= owner_oh;
                  if (cnt_q == '0) begin
                     state_q <= StDone;
                  end else begin
                     cnt_q   <= cnt_q - 1'b1;
                     state_q <= StSend;
                  end
               end else if (tmo_hit) begin
                  err_q   <= owner_oh;
                  state_q <= StDone;
               end else begin
`ifdef SPI_SCHED_TIMEOUT_EN
                  tmo_q <= tmo_q + 1'b1;
`endif
               end
            end
            StDone: begin
               done_q  <= owner_oh;
               last_q  <= owner_q;
               grant_q <= '0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_grant             = grant_q;
   assign o_data_ack          = ack_q;
   assign o_rd_data           = rd_data_q;
   assign o_rd_valid          = rd_valid_q;
   assign o_done              = done_q;
   assign o_err               = err_q;
   assign o_spi_slave_num     = slave_q;
   assign o_spi_tx_data       = tx_data_q;
   assign o_spi_tx_data_valid = tx_valid_q;

endmodule
